// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types and constants for the hazard/forwarding scoreboard.
// Supersedes the fixed three-way forwarding select used by the legacy core.
package hazard_pkg;

    localparam logic [4:0] REG_X0 = 5'd0;
    localparam int DEF_FWD_STAGES = 2;

    function automatic int sel_width(input int num_stages);
        return $clog2(num_stages + 1);
    endfunction

    localparam int FWD_SEL_W = sel_width(DEF_FWD_STAGES);

    typedef logic [FWD_SEL_W-1:0] fwd_sel_t;
    typedef logic [4:0]           reg_idx_t;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// ID/EX hazard bus: pipeline-side operand/stage info in, forwarding selects and stall out.
interface hazard_scoreboard_unit_if
    import hazard_pkg::*;
#(
    parameter int NUM_SRC        = 2,
    parameter int NUM_FWD_STAGES = 2,
    parameter int CNT_W          = 32
) ();
    localparam int SEL_W = sel_width(NUM_FWD_STAGES);

    logic [NUM_SRC-1:0][4:0]        rs_ex;
    logic [NUM_SRC-1:0]             rs_used_ex;
    logic [NUM_FWD_STAGES-1:0][4:0] rd_stage;
    logic [NUM_FWD_STAGES-1:0]      wr_en_stage;
    logic [NUM_FWD_STAGES-1:0]      data_rdy_stage;
    logic                           ll_issue_valid;
    reg_idx_t                       ll_issue_rd;
    logic                           ll_issue_ready;
    logic                           ll_done_valid;
    reg_idx_t                       ll_done_rd;
    logic [NUM_SRC-1:0][SEL_W-1:0]  fwd_sel;
    logic                           stall;
    logic [CNT_W-1:0]               stall_cnt;

    modport master (
        output rs_ex, rs_used_ex, rd_stage, wr_en_stage, data_rdy_stage,
        output ll_issue_valid, ll_issue_rd, ll_done_valid, ll_done_rd,
        input  ll_issue_ready, fwd_sel, stall, stall_cnt
    );

    modport slave (
        input  rs_ex, rs_used_ex, rd_stage, wr_en_stage, data_rdy_stage,
        input  ll_issue_valid, ll_issue_rd, ll_done_valid, ll_done_rd,
        output ll_issue_ready, fwd_sel, stall, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_unit_fwd_select.sv
// Per-operand forwarding priority match and blocked flag.
// Stage 0 is youngest; the youngest matching stage decides both select and readiness.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int NUM_FWD_STAGES = 2,
    parameter int SEL_W          = sel_width(NUM_FWD_STAGES)
) (
    input  reg_idx_t                       rs,
    input  logic                           rs_used,
    input  logic [NUM_FWD_STAGES-1:0][4:0] rd_stage,
    input  logic [NUM_FWD_STAGES-1:0]      wr_en_stage,
    input  logic [NUM_FWD_STAGES-1:0]      data_rdy_stage,
    input  logic [31:0]                    pending,
    output logic [SEL_W-1:0]               sel,
    output logic                           blocked
);

    logic hit;
    logic hit_rdy;

    // Scan oldest to youngest so a younger match overwrites an older one.
    always_comb begin
        sel     = '0;
        hit     = 1'b0;
        hit_rdy = 1'b1;
        for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
            if (wr_en_stage[k] && (rd_stage[k] == rs) && (rs != REG_X0)) begin
                sel     = SEL_W'(k + 1);
                hit     = 1'b1;
                hit_rdy = data_rdy_stage[k];
            end
        end
    end

    always_comb begin
        blocked = 1'b0;
        if (rs_used && (rs != REG_X0)) begin
            blocked = hit ? !hit_rdy : pending[rs];
        end
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID/EX hazard unit: operand forwarding, long-latency scoreboard and stall generation.
// Holds the pending-register bitmap, outstanding-op counter and saturating stall counter.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC         = 2,
    parameter int NUM_FWD_STAGES  = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 32
) (
    input logic                     clk,
    input logic                     rst,
    hazard_scoreboard_unit_if.slave bus
);

    localparam int SEL_W = sel_width(NUM_FWD_STAGES);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    logic [31:0]                   pending;
    logic [OUT_W-1:0]              outstanding;
    logic [CNT_W-1:0]              stall_cnt;
    logic [NUM_SRC-1:0]            blocked;
    logic [NUM_SRC-1:0][SEL_W-1:0] sel;
    logic                          issue_fire;
    logic                          dec_ok;
    logic                          stall_int;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_select #(
            .NUM_FWD_STAGES (NUM_FWD_STAGES),
            .SEL_W          (SEL_W)
        ) u_fwd_select (
            .rs             (bus.rs_ex[i]),
            .rs_used        (bus.rs_used_ex[i]),
            .rd_stage       (bus.rd_stage),
            .wr_en_stage    (bus.wr_en_stage),
            .data_rdy_stage (bus.data_rdy_stage),
            .pending        (pending),
            .sel            (sel[i]),
            .blocked        (blocked[i])
        );
    end

    assign issue_fire = bus.ll_issue_valid && bus.ll_issue_ready;
    assign dec_ok     = bus.ll_done_valid && (outstanding != '0);

    // Combinational outputs are forced to their idle values while reset is held.
    assign stall_int          = !rst && (|blocked);
    assign bus.stall          = stall_int;
    assign bus.fwd_sel        = rst ? '0 : sel;
    assign bus.ll_issue_ready = (outstanding != OUT_MAX);
    assign bus.stall_cnt      = stall_cnt;

    // Set after clear: an issue and a done to the same rd leaves the new producer pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            if (bus.ll_done_valid && (bus.ll_done_rd != REG_X0)) begin
                pending[bus.ll_done_rd] <= 1'b0;
            end
            if (issue_fire && (bus.ll_issue_rd != REG_X0)) begin
                pending[bus.ll_issue_rd] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({issue_fire, dec_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_int && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Protocol errors are absorbed: a refused issue or a done with nothing in flight must not move the count.
    a_issue_refused: assert property (@(posedge clk) disable iff (rst)
        (bus.ll_issue_valid && !bus.ll_issue_ready && !bus.ll_done_valid) |=> (outstanding == OUT_MAX));

    a_done_underflow: assert property (@(posedge clk) disable iff (rst)
        (bus.ll_done_valid && (outstanding == '0) && !issue_fire) |=> (outstanding == '0));

endmodule
